// File: rtl/mult_div_pkg.sv
// Shared types and constants for the iterative signed multiply/divide sequencer.
// The optional divide-by-zero exception is controlled by the DIVZERO_EXCP_EN macro.
package mult_div_pkg;

    // Sequencer states; EXCP exists only when the exception feature is built in.
    typedef enum logic [2:0] {
        S_IDLE,
        S_ITER,
        S_FIX,
        S_DONE
`ifdef DIVZERO_EXCP_EN
        ,
        S_EXCP
`endif
    } state_t;

    // Operation select encoding for op_div.
    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    // The CPU instantiates the sequencer at 32 bits.
    localparam int DEF_WIDTH    = 32;
    // Cycles from the accepting start edge to the DONE cycle.
    localparam int DONE_LATENCY = DEF_WIDTH + 2;
    // Counter width able to hold WIDTH-1.
    localparam int CNT_W        = $clog2(DEF_WIDTH);

endpackage

// File: rtl/mult_div_seq.sv
// Iterative signed multiply (shift-add) / divide (restoring) sequencer.
// One iteration per cycle on operand magnitudes, then a sign-fix cycle and a
// one-cycle DONE that strobes hi_write/lo_write.
// Optional feature: DIVZERO_EXCP_EN makes a divide by zero raise div_zero
// instead of running the normal path.
module mult_div_seq
    import mult_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_div,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             hi_write,
    output logic             lo_write
);

    localparam int CW = $clog2(WIDTH);

    // Two's-complement magnitude as unsigned WIDTH bits (most negative maps to itself).
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    state_t           state, next_state;
    logic [WIDTH-1:0] hi_r;      // accumulator (mult) / remainder (div)
    logic [WIDTH-1:0] lo_r;      // multiplier (mult) / quotient (div)
    logic [WIDTH-1:0] opb_r;     // multiplicand (mult) / divisor (div)
    logic             op_r;
    logic             sign_a_r;
    logic             sign_b_r;
    logic             bzero_r;
    logic [CW-1:0]    cnt;

    // Iteration datapath for one cycle of either algorithm.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] iter_hi, iter_lo;

    // Next-cycle iteration values for the selected operation.
    always_comb begin
        mul_sum   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opb_r} : '0);
        div_shift = {hi_r, lo_r[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opb_r};
        if (op_r == OP_DIV) begin
            // When the trial subtraction succeeds the difference fits in WIDTH bits.
            iter_hi = div_ge ? (div_shift[WIDTH-1:0] - opb_r) : div_shift[WIDTH-1:0];
            iter_lo = {lo_r[WIDTH-2:0], div_ge};
        end else begin
            iter_hi = mul_sum[WIDTH:1];
            iter_lo = {mul_sum[0], lo_r[WIDTH-1:1]};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments so every
        // flop samples pre-edge values regardless of statement order.
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // Next-state and handshake/strobe outputs.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        next_state = state;
        busy       = (state != S_IDLE);
        done       = 1'b0;
        div_zero   = 1'b0;
        hi_write   = 1'b0;
        lo_write   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
`ifdef DIVZERO_EXCP_EN
                    if (op_div == OP_DIV && b_in == '0) next_state = S_EXCP;
                    else                                next_state = S_ITER;
`else
                    next_state = S_ITER;
`endif
                end
            end
            S_ITER: if (cnt == '0) next_state = S_FIX;
            S_FIX:  next_state = S_DONE;
            S_DONE: begin
                done       = 1'b1;
                hi_write   = 1'b1;
                lo_write   = 1'b1;
                next_state = S_IDLE;
            end
`ifdef DIVZERO_EXCP_EN
            S_EXCP: begin
                done       = 1'b1;
                div_zero   = 1'b1;
                next_state = S_IDLE;
            end
`endif
            default: next_state = S_IDLE;
        endcase
    end

    // Operand capture, iteration, sign fix-up and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_r     <= '0;
            lo_r     <= '0;
            opb_r    <= '0;
            op_r     <= OP_MULT;
            sign_a_r <= 1'b0;
            sign_b_r <= 1'b0;
            bzero_r  <= 1'b0;
            cnt      <= '0;
            hi_out   <= '0;
            lo_out   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (next_state == S_ITER) begin
                        // Both algorithms start with a zero upper half; the operand
                        // that gets shifted sits in lo_r, the other in opb_r.
                        hi_r     <= '0;
                        lo_r     <= (op_div == OP_DIV) ? mag(a_in) : mag(b_in);
                        opb_r    <= (op_div == OP_DIV) ? mag(b_in) : mag(a_in);
                        op_r     <= op_div;
                        sign_a_r <= a_in[WIDTH-1];
                        sign_b_r <= b_in[WIDTH-1];
                        bzero_r  <= (op_div == OP_DIV) && (b_in == '0);
                        cnt      <= CW'(WIDTH - 1);
                    end
                end
                S_ITER: begin
                    hi_r <= iter_hi;
                    lo_r <= iter_lo;
                    cnt  <= cnt - CW'(1);
                end
                S_FIX: begin
                    if (op_r == OP_DIV) begin
                        // Dividing by zero leaves |a| in the remainder, so the
                        // dividend-sign fix restores the raw dividend in Hi.
                        lo_out <= bzero_r ? '1 : ((sign_a_r ^ sign_b_r) ? -lo_r : lo_r);
                        hi_out <= sign_a_r ? -hi_r : hi_r;
                    end else begin
                        {hi_out, lo_out} <= (sign_a_r ^ sign_b_r) ? -{hi_r, lo_r} : {hi_r, lo_r};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_seq.sv
// Directed bench for mult_div_seq: a vector table of signed mult/div results
// plus hand sequences for start filtering, mid-operation reset and divide by zero.
module tb_mult_div_seq;
    import mult_div_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         op_div;
    logic [W-1:0] a_in, b_in;
    logic         busy, done, div_zero, hi_write, lo_write;
    logic [W-1:0] hi_out, lo_out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mult_div_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op_div   (op_div),
        .a_in     (a_in),
        .b_in     (b_in),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi_out   (hi_out),
        .lo_out   (lo_out),
        .hi_write (hi_write),
        .lo_write (lo_write)
    );

    typedef struct {
        string        name;
        logic         op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Start one operation, then watch a fixed window of cycles after the start edge.
    // lat is the cycle index (1 = first cycle after the start edge) of the first done.
    task automatic run_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] hi, output logic [W-1:0] lo,
                          output int lat, output int ndone, output int nwr,
                          output int ndz, output logic held);
        @(negedge clk);
        op_div = op;
        a_in   = a;
        b_in   = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a_in  = $urandom;
        b_in  = $urandom;
        hi    = 'x;
        lo    = 'x;
        lat   = -1;
        ndone = 0;
        nwr   = 0;
        ndz   = 0;
        for (int k = 1; k <= DONE_LATENCY + 4; k++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (lat < 0) begin
                    lat = k;
                    hi  = hi_out;
                    lo  = lo_out;
                end
            end
            if (hi_write && lo_write) nwr++;
            if (hi_write != lo_write) nwr += 100;
            if (div_zero) ndz++;
        end
        held = (hi_out === hi) && (lo_out === lo);
    endtask

    logic [W-1:0] r_hi, r_lo, prev_hi, prev_lo, lo1, lo2, hi2, hi11, lo11;
    int           lat, ndone, nwr, ndz, first_done, second_done, ab_done, ab_wr;
    logic         held, busy36, busy11;

    initial begin
        vecs[0] = '{"mul_7_m3",      OP_MULT, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[1] = '{"mul_max_max",   OP_MULT, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
        vecs[2] = '{"mul_min_min",   OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[3] = '{"mul_m1_m1",     OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[4] = '{"mul_zero",      OP_MULT, 32'd0,        32'd12345,    32'h00000000, 32'h00000000};
        vecs[5] = '{"div_m7_2",      OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[6] = '{"div_ovf",       OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[7] = '{"div_100_7",     OP_DIV,  32'd100,      32'd7,        32'h00000002, 32'h0000000E};
        vecs[8] = '{"div_7_m2",      OP_DIV,  32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[9] = '{"div_0_5",       OP_DIV,  32'd0,        32'd5,        32'h00000000, 32'h00000000};

        reset  = 1'b1;
        start  = 1'b0;
        op_div = 1'b0;
        a_in   = '0;
        b_in   = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy",     busy,     1'b0);
        check("rst_done",     done,     1'b0);
        check("rst_div_zero", div_zero, 1'b0);
        check("rst_strobes",  {hi_write, lo_write}, 2'b00);
        check("rst_hi",       hi_out,   '0);
        check("rst_lo",       lo_out,   '0);

        // Table-driven results, latency, strobe width and hold-after-DONE.
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, r_hi, r_lo, lat, ndone, nwr, ndz, held);
            check({vecs[i].name, "_hi"},      r_hi,  vecs[i].hi);
            check({vecs[i].name, "_lo"},      r_lo,  vecs[i].lo);
            check({vecs[i].name, "_latency"}, lat,   DONE_LATENCY);
            check({vecs[i].name, "_ndone"},   ndone, 1);
            check({vecs[i].name, "_strobes"}, nwr,   1);
            check({vecs[i].name, "_divzero"}, ndz,   0);
            check({vecs[i].name, "_held"},    held,  1'b1);
        end

        // Divide by zero.
        prev_hi = hi_out;
        prev_lo = lo_out;
        run_op(OP_DIV, 32'd5, 32'd0, r_hi, r_lo, lat, ndone, nwr, ndz, held);
`ifdef DIVZERO_EXCP_EN
        check("dz_latency", lat,   1);
        check("dz_ndone",   ndone, 1);
        check("dz_strobes", nwr,   0);
        check("dz_pulse",   ndz,   1);
        check("dz_hi_kept", hi_out, prev_hi);
        check("dz_lo_kept", lo_out, prev_lo);
`else
        check("dz_latency", lat,   DONE_LATENCY);
        check("dz_ndone",   ndone, 1);
        check("dz_strobes", nwr,   1);
        check("dz_pulse",   ndz,   0);
        check("dz_hi",      r_hi,  32'd5);
        check("dz_lo",      r_lo,  32'hFFFFFFFF);
        run_op(OP_DIV, 32'hFFFFFFFB, 32'd0, r_hi, r_lo, lat, ndone, nwr, ndz, held);
        check("dz_neg_hi",  r_hi,  32'hFFFFFFFB);
        check("dz_neg_lo",  r_lo,  32'hFFFFFFFF);
`endif

        // start while busy (T+5, and in DONE at T+34) is ignored; T+35 is accepted.
        @(negedge clk);
        op_div = OP_MULT;
        a_in   = 32'd6;
        b_in   = 32'd7;
        start  = 1'b1;
        @(posedge clk);
        #1;
        first_done  = -1;
        second_done = -1;
        ndone       = 0;
        busy36      = 1'b0;
        for (int c = 1; c <= 72; c++) begin
            start = (c == 5) || (c == 34) || (c == 35);
            if (c == 5) a_in = 32'd99;
            if (c == 35) begin
                a_in = 32'd3;
                b_in = 32'd5;
            end
            @(negedge clk);
            if (done) begin
                if (c <= 34) begin
                    ndone++;
                    first_done = c;
                    lo1 = lo_out;
                end else if (second_done < 0) begin
                    second_done = c;
                    lo2 = lo_out;
                end
            end
            if (c == 36) busy36 = busy;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        check("ign_ndone",       ndone,       1);
        check("ign_done_cycle",  first_done,  DONE_LATENCY);
        check("ign_lo",          lo1,         32'd42);
        check("b2b_busy",        busy36,      1'b1);
        check("b2b_done_cycle",  second_done, 35 + DONE_LATENCY);
        check("b2b_lo",          lo2,         32'd15);

        // Reset at T+10 aborts a divide; multiply 3x4 started at T+12.
        @(negedge clk);
        op_div = OP_DIV;
        a_in   = 32'd100;
        b_in   = 32'd7;
        start  = 1'b1;
        @(posedge clk);
        #1;
        ab_done     = 0;
        ab_wr       = 0;
        second_done = -1;
        busy11      = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            reset = (c == 10);
            start = (c == 12);
            if (c == 12) begin
                op_div = OP_MULT;
                a_in   = 32'd3;
                b_in   = 32'd4;
            end
            @(negedge clk);
            if (c <= 11) begin
                if (done) ab_done++;
                if (hi_write || lo_write) ab_wr++;
            end
            if (c == 11) begin
                busy11 = busy;
                hi11   = hi_out;
                lo11   = lo_out;
            end
            if (done && c > 11 && second_done < 0) begin
                second_done = c;
                hi2 = hi_out;
                lo2 = lo_out;
            end
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        start = 1'b0;
        check("abort_busy",       busy11,      1'b0);
        check("abort_no_done",    ab_done,     0);
        check("abort_no_strobe",  ab_wr,       0);
        check("abort_hi_cleared", hi11,        '0);
        check("abort_lo_cleared", lo11,        '0);
        check("restart_cycle",    second_done, 12 + DONE_LATENCY);
        check("restart_hi",       hi2,         32'd0);
        check("restart_lo",       lo2,         32'd12);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
